instruction_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit core. It owns the program counter, drives the instruction memory address and latches the returned 8-bit instruction code into an instruction register. It decodes the instruction and sequences the register file and ALU through fetch/decode/execute/writeback. Sits between Instruction_Memory and the register file/ALU datapath.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/instr_decoder.sv | 19 +
 rtl/instruction_sequencer.sv | 130 +++++++++++++
 tb/tb_instruction_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core control path: opcodes, FSM states,
// instruction field positions and the decoded-instruction bundle.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned IMM_W      = 6;
  localparam int unsigned RETIRE_W   = 8;

  localparam int unsigned OPC_HI = 7;
  localparam int unsigned OPC_LO = 6;
  localparam int unsigned RD_HI  = 5;
  localparam int unsigned RD_LO  = 3;
  localparam int unsigned RS_HI  = 2;
  localparam int unsigned RS_LO  = 0;
  localparam int unsigned IMM_HI = 5;
  localparam int unsigned IMM_LO = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SLL  = 2'b01,
    OP_HALT = 2'b10,
    OP_JMP  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef struct packed {
    opcode_e               opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] shamt;
    logic [IMM_W-1:0]      imm;
    logic                  alu_op;
  } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Pure field extraction from the instruction register.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output decode_t            dec
);

  opcode_e opcode;

  assign opcode     = opcode_e'(ir[OPC_HI:OPC_LO]);
  assign dec.opcode = opcode;
  assign dec.rd     = ir[RD_HI:RD_LO];
  assign dec.rs     = ir[RS_HI:RS_LO];
  assign dec.shamt  = ir[RS_HI:RS_LO];
  assign dec.imm    = ir[IMM_HI:IMM_LO];
  assign dec.alu_op = (opcode == OP_SLL);

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: owns PC and IR and
// strobes the register file / ALU controls.
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned PROG_LEN = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [INSTR_W-1:0]    instruction_code,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] shamt,
  output logic                  alu_op,
  output logic                  reg_write,
  output logic                  busy,
  output logic                  halted,
  output logic [RETIRE_W-1:0]   retired
);

  // One extra bit so PROG_LEN = 2^PC_WIDTH is representable.
  localparam logic [PC_WIDTH:0] PROG_END = (PC_WIDTH + 1)'(PROG_LEN);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  busy_d, halted_d, reg_write_d, alu_op_d;
  logic                  pc_out_of_range;
  logic [PC_WIDTH-1:0]   jump_target;
  logic [RETIRE_W-1:0]   retired_inc;
  decode_t               dec;

  instr_decoder u_decoder (
    .ir  (ir_q),
    .dec (dec)
  );

  assign pc_out_of_range = ({1'b0, pc_q} >= PROG_END);
  // Sign-extended 6-bit offset relative to the following instruction.
  assign jump_target     = pc_q + PC_WIDTH'(1) + PC_WIDTH'($signed(dec.imm));
  assign retired_inc     = (retired_q == {RETIRE_W{1'b1}}) ? retired_q
                                                           : retired_q + RETIRE_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (pc_out_of_range) begin
          state_d = ST_HALT;
        end else begin
          ir_d    = instruction_code;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (dec.opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (dec.opcode == OP_JMP) begin
          pc_d      = jump_target;
          retired_d = retired_inc;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        pc_d      = pc_q + PC_WIDTH'(1);
        retired_d = retired_inc;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          pc_d      = '0;
          retired_d = '0;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they align with it.
    busy_d      = state_d inside {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK};
    halted_d    = (state_d == ST_HALT);
    reg_write_d = (state_d == ST_WRITEBACK);
    alu_op_d    = (state_d inside {ST_EXECUTE, ST_WRITEBACK}) && dec.alu_op;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      reg_write <= 1'b0;
      alu_op    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      busy      <= busy_d;
      halted    <= halted_d;
      reg_write <= reg_write_d;
      alu_op    <= alu_op_d;
    end
  end

  assign PC      = pc_q;
  assign retired = retired_q;
  assign rd_addr = dec.rd;
  assign rs_addr = dec.rs;
  assign shamt   = dec.shamt;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: an instruction-level reference model expands each
// program into an expected per-cycle trace that the DUT is compared against.
module tb_instruction_sequencer;

  localparam int unsigned PROG_LEN = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] instruction_code;
  logic [7:0] PC;
  logic [2:0] rd_addr, rs_addr, shamt;
  logic       alu_op, reg_write, busy, halted;
  logic [7:0] retired;

  logic [7:0] mem [256];
  assign instruction_code = mem[PC];

  instruction_sequencer #(.PC_WIDTH(8), .PROG_LEN(PROG_LEN)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .instruction_code (instruction_code),
    .PC               (PC),
    .rd_addr          (rd_addr),
    .rs_addr          (rs_addr),
    .shamt            (shamt),
    .alu_op           (alu_op),
    .reg_write        (reg_write),
    .busy             (busy),
    .halted           (halted),
    .retired          (retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  // phase: 0 fetch, 1 decode, 2 execute, 3 writeback, 4 halted
  typedef struct {
    int         pc;
    int         ret;
    int         phase;
    logic [7:0] ir;
  } exp_t;

  exp_t tr[$];
  bit   tr_halts;
  logic [2:0] rw_log[$];

  always @(negedge clk) if (reg_write === 1'b1) rw_log.push_back(rd_addr);

  function automatic void push(int pc, int ret, int phase, logic [7:0] ir);
    exp_t e;
    e.pc = pc; e.ret = ret; e.phase = phase; e.ir = ir;
    tr.push_back(e);
  endfunction

  // Instruction-level reference: each instruction contributes its latency in cycles.
  function automatic void build_trace(int limit);
    int pc = 0;
    int ret = 0;
    int imm;
    logic [7:0] ir;
    tr.delete();
    tr_halts = 0;
    while (tr.size() < limit) begin
      if (pc >= PROG_LEN) begin
        push(pc, ret, 0, 8'h00);
        push(pc, ret, 4, 8'h00);
        push(pc, ret, 4, 8'h00);
        tr_halts = 1;
        break;
      end
      ir = mem[pc];
      push(pc, ret, 0, ir);
      push(pc, ret, 1, ir);
      if (ir[7:6] == 2'b10) begin
        push(pc, ret, 4, ir);
        push(pc, ret, 4, ir);
        tr_halts = 1;
        break;
      end
      push(pc, ret, 2, ir);
      if (ir[7:6] == 2'b11) begin
        imm = $signed(ir[5:0]);
        pc  = (pc + 1 + imm) & 255;
      end else begin
        push(pc, ret, 3, ir);
        pc = (pc + 1) & 255;
      end
      ret = (ret < 255) ? ret + 1 : 255;
    end
  endfunction

  task automatic check_cycle(input exp_t e);
    check_eq("pc", 32'(PC), e.pc);
    check_eq("busy", 32'(busy), (e.phase < 4) ? 1 : 0);
    check_eq("halted", 32'(halted), (e.phase == 4) ? 1 : 0);
    check_eq("reg_write", 32'(reg_write), (e.phase == 3) ? 1 : 0);
    check_eq("retired", 32'(retired), e.ret);
    if (e.phase >= 1 && e.phase <= 3) begin
      check_eq("rd_addr", 32'(rd_addr), 32'(e.ir[5:3]));
      check_eq("rs_addr", 32'(rs_addr), 32'(e.ir[2:0]));
      check_eq("shamt", 32'(shamt), 32'(e.ir[2:0]));
    end
    if (e.phase == 2 || e.phase == 3)
      check_eq("alu_op", 32'(alu_op), (e.ir[7:6] == 2'b01) ? 1 : 0);
  endtask

  task automatic reset_checks();
    check_eq("rst_pc", 32'(PC), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_reg_write", 32'(reg_write), 0);
    check_eq("rst_alu_op", 32'(alu_op), 0);
    check_eq("rst_retired", 32'(retired), 0);
    check_eq("rst_rd_addr", 32'(rd_addr), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    reset = 1'b0;
  endtask

  // Pulse start, then follow the trace; optionally toggle start while busy
  // and optionally reset during an execute cycle at or after reset_after.
  task automatic run_trace(input bit rand_start, input int reset_after);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    foreach (tr[i]) begin
      cyc = i;
      check_cycle(tr[i]);
      if (reset_after >= 0 && i >= reset_after && tr[i].phase == 2) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset_checks();
        reset = 1'b0;
        break;
      end
      if (i < tr.size() - 1) begin
        start = (rand_start && tr[i].phase < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    foreach (mem[i]) mem[i] = 8'h80;

    apply_reset();

    // Directed program: add/sll/add/jump-over/add, halt at address 6.
    mem[0] = 8'h25; mem[1] = 8'h61; mem[2] = 8'h2C;
    mem[3] = 8'hC1; mem[4] = 8'h6B; mem[5] = 8'h1D;
    rw_log.delete();
    build_trace(200);
    run_trace(1'b0, -1);
    check_eq("prog_retired", 32'(retired), 5);
    check_eq("prog_halted", 32'(halted), 1);
    check_eq("prog_rw_count", rw_log.size(), 4);
    if (rw_log.size() == 4) begin
      check_eq("prog_rd0", 32'(rw_log[0]), 4);
      check_eq("prog_rd1", 32'(rw_log[1]), 4);
      check_eq("prog_rd2", 32'(rw_log[2]), 5);
      check_eq("prog_rd3", 32'(rw_log[3]), 3);
    end

    // Halt opcode at PC 0, restarted from HALT.
    mem[0] = 8'h80;
    rw_log.delete();
    build_trace(50);
    run_trace(1'b0, -1);
    check_eq("halt0_rw_count", rw_log.size(), 0);

    // Jump +31 from PC 0 lands beyond the program.
    mem[0] = 8'hDF;
    build_trace(50);
    run_trace(1'b1, -1);
    check_eq("far_jump_pc", 32'(PC), 32);
    check_eq("far_jump_halted", 32'(halted), 1);

    // Jump-to-self at PC 2, then reset in the middle of an execute cycle.
    mem[0] = 8'h25; mem[1] = 8'h61; mem[2] = 8'hFF;
    build_trace(60);
    run_trace(1'b1, 20);

    // Long self-loop saturates the retired counter.
    mem[0] = 8'hFF;
    build_trace(930);
    run_trace(1'b1, -1);
    check_eq("sat_retired", 32'(retired), 255);
    apply_reset();

    // Random programs.
    for (int t = 0; t < 12; t++) begin
      for (int a = 0; a < PROG_LEN; a++) mem[a] = 8'($urandom);
      build_trace(150);
      run_trace(1'b1, -1);
      if (!tr_halts) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
